// File: rtl/ahb_mux_pkg.sv
// Shared constants and state types for the AHB-Lite decode/mux slice.
package ahb_mux_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    localparam int MAX_SLAVES = 16;

    // Two-cycle ERROR sequencer used by the default slave.
    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } d_state_e;

    // Watchdog termination states; the watchdog reuses the ERROR sequencer,
    // so these share encodings with d_state_e (W_RUN = D_IDLE, ...).
    typedef enum logic [1:0] {
        W_RUN = 2'd0,
        W_TO1 = 2'd1,
        W_TO2 = 2'd2
    } w_state_e;

endpackage

// File: rtl/ahb_mux_default_slave.sv
// Two-cycle AHB ERROR response generator.
//
// state  | meaning
// D_IDLE | no error response in progress (ready=1, resp=OKAY)
// D_ERR1 | first ERROR cycle (ready=0, resp=ERROR)
// D_ERR2 | second ERROR cycle (ready=1, resp=ERROR), may chain into D_ERR1
module ahb_mux_default_slave
    import ahb_mux_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic ready,
    output logic resp,
    output logic busy
);

    d_state_e state, state_n;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= D_IDLE;
        else     state <= state_n;
    end

    // Next-state logic; outputs are decoded from state alone so the
    // master-facing HREADY never loops back through start.
    always_comb begin
        state_n = state;
        case (state)
            D_IDLE:  if (start) state_n = D_ERR1;
            D_ERR1:  state_n = D_ERR2;
            D_ERR2:  state_n = start ? D_ERR1 : D_IDLE;
            default: state_n = D_IDLE;
        endcase
    end

    assign ready = (state != D_ERR1);
    assign resp  = (state != D_IDLE) ? RESP_ERROR : RESP_OKAY;
    assign busy  = (state != D_IDLE);

endmodule

// File: rtl/ahb_decode_mux_param.sv
// AHB-Lite address decoder, response mux, default slave and stall watchdog.
module ahb_decode_mux_param
    import ahb_mux_pkg::*;
#(
    parameter int                         NUM_SLAVES     = 2,
    parameter logic [NUM_SLAVES*32-1:0]   BASE_ADDRS     = {32'h60010000, 32'h60000000},
    parameter logic [NUM_SLAVES*32-1:0]   MASK_ADDRS     = {32'hFFFFF000, 32'hFFFF0000},
    parameter int                         TIMEOUT_CYCLES = 256,
    parameter int                         IDW            = 4
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [31:0]              HADDR,
    input  logic [1:0]               HTRANS,
    output logic [NUM_SLAVES-1:0]    HSELS,
    input  logic [NUM_SLAVES-1:0]    HREADYOUTS,
    input  logic [NUM_SLAVES-1:0]    HRESPS,
    input  logic [NUM_SLAVES*32-1:0] HRDATAS,
    output logic                     HREADY,
    output logic                     HRESP,
    output logic [31:0]              HRDATA,
    output logic                     timeout_flag,
    output logic [IDW-1:0]           timeout_id,
    input  logic                     timeout_clr
);

    // dsel one-hot layout: [NUM_SLAVES-1:0] slaves, then default slave, then none.
    localparam int DEF = NUM_SLAVES;
    localparam int NONE = NUM_SLAVES + 1;
    localparam int DW = NUM_SLAVES + 2;

    logic [NUM_SLAVES-1:0] sel;
    logic                  dec_hit;
    logic [DW-1:0]         dsel;
    logic                  def_start, def_ready, def_resp, def_busy;
    logic                  wd_ready, wd_resp, wd_busy;
    logic                  stall;
    logic [IDW-1:0]        sidx;
    logic                  unused_bits;

    assign unused_bits = HTRANS[0];

    // Address decode; lowest matching index wins.
    always_comb begin
        sel     = '0;
        dec_hit = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!dec_hit && ((HADDR & MASK_ADDRS[i*32 +: 32]) == BASE_ADDRS[i*32 +: 32])) begin
                sel[i]  = 1'b1;
                dec_hit = 1'b1;
            end
        end
    end

    assign HSELS = sel;

    // Data-phase target, captured whenever the bus accepts an address phase.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dsel       <= '0;
            dsel[NONE] <= 1'b1;
        end else if (HREADY) begin
            dsel <= '0;
            if (HTRANS[1]) begin
                if (dec_hit) dsel[NUM_SLAVES-1:0] <= sel;
                else         dsel[DEF] <= 1'b1;
            end else begin
                dsel[NONE] <= 1'b1;
            end
        end
    end

    assign def_start = HREADY & HTRANS[1] & ~dec_hit;

    ahb_mux_default_slave u_def (
        .clk   (HCLK),
        .rst   (HRESET),
        .start (def_start),
        .ready (def_ready),
        .resp  (def_resp),
        .busy  (def_busy)
    );

    // Which slave owns the data phase and whether it is holding the bus.
    always_comb begin
        stall = 1'b0;
        sidx  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel[i]) begin
                stall = ~HREADYOUTS[i];
                sidx  = IDW'(i);
            end
        end
    end

    // Response mux; a watchdog termination overrides the stalled slave.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = RESP_OKAY;
        HRDATA = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel[i]) begin
                HREADY = HREADYOUTS[i];
                HRESP  = HRESPS[i];
                HRDATA = HRDATAS[i*32 +: 32];
            end
        end
        if (dsel[DEF] && def_busy) begin
            HREADY = def_ready;
            HRESP  = def_resp;
        end
        if (wd_busy) begin
            HREADY = wd_ready;
            HRESP  = wd_resp;
            HRDATA = '0;
        end
    end

    if (TIMEOUT_CYCLES > 0) begin : g_wd
        localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
        logic [CW-1:0] cnt;
        logic          expire;

        // Expiry fires on the stall cycle that would take cnt to the limit,
        // so a slave that becomes ready in that very cycle still completes.
        assign expire = ~wd_busy & stall & (cnt == CW'(TIMEOUT_CYCLES - 1));

        // Saturating stall counter, cleared by any completed transfer.
        always_ff @(posedge HCLK or posedge HRESET) begin
            if (HRESET)                                             cnt <= '0;
            else if (HREADY)                                        cnt <= '0;
            else if (~wd_busy && stall && cnt != CW'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
        end

        // Sticky flag and culprit index; a new expiry beats a clear.
        always_ff @(posedge HCLK or posedge HRESET) begin
            if (HRESET) begin
                timeout_flag <= 1'b0;
                timeout_id   <= '0;
            end else if (expire) begin
                timeout_flag <= 1'b1;
                timeout_id   <= sidx;
            end else if (timeout_clr) begin
                timeout_flag <= 1'b0;
            end
        end

        ahb_mux_default_slave u_wd_term (
            .clk   (HCLK),
            .rst   (HRESET),
            .start (expire),
            .ready (wd_ready),
            .resp  (wd_resp),
            .busy  (wd_busy)
        );
    end else begin : g_no_wd
        assign wd_ready     = 1'b1;
        assign wd_resp      = RESP_OKAY;
        assign wd_busy      = 1'b0;
        assign timeout_flag = 1'b0;
        assign timeout_id   = '0;
    end

endmodule

// File: tb/tb_ahb_decode_mux_param.sv
// Directed bench for ahb_decode_mux_param (2 slaves, 8-cycle watchdog).
module tb_ahb_decode_mux_param;

    localparam logic [31:0] D0 = 32'hA0A0A0A0;
    localparam logic [31:0] D1 = 32'hB1B1B1B1;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [1:0]  hsels;
    logic [1:0]  hreadyouts;
    logic [1:0]  hresps;
    logic [63:0] hrdatas;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic        timeout_flag;
    logic [3:0]  timeout_id;
    logic        timeout_clr;

    int total = 0;
    int fails = 0;

    always #5 hclk = ~hclk;

    ahb_decode_mux_param #(
        .NUM_SLAVES     (2),
        .BASE_ADDRS     ({32'h60010000, 32'h60000000}),
        .MASK_ADDRS     ({32'hFFFFF000, 32'hFFFF0000}),
        .TIMEOUT_CYCLES (8),
        .IDW            (4)
    ) dut (
        .HCLK         (hclk),
        .HRESET       (hreset),
        .HADDR        (haddr),
        .HTRANS       (htrans),
        .HSELS        (hsels),
        .HREADYOUTS   (hreadyouts),
        .HRESPS       (hresps),
        .HRDATAS      (hrdatas),
        .HREADY       (hready),
        .HRESP        (hresp),
        .HRDATA       (hrdata),
        .timeout_flag (timeout_flag),
        .timeout_id   (timeout_id),
        .timeout_clr  (timeout_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus(input logic r, input logic p, input logic [31:0] d, input string tag);
        #1;
        chk({tag, "_ready"}, 32'(hready), 32'(r));
        chk({tag, "_resp"},  32'(hresp),  32'(p));
        chk({tag, "_data"},  hrdata,      d);
    endtask

    initial begin
        hreset = 1'b1; haddr = 32'h0; htrans = 2'b00; hreadyouts = 2'b11;
        hresps = 2'b00; hrdatas = {D1, D0}; timeout_clr = 1'b0;
        bus(1'b1, 1'b0, 32'h0, "reset");
        chk("reset_flag", 32'(timeout_flag), 32'd0);
        chk("reset_id", 32'(timeout_id), 32'd0);
        step(); step();
        hreset = 1'b0;

        // write then read to slave 1, zero wait states
        step(); haddr = 32'h60010004; htrans = 2'b10;
        #1 chk("wr_hsels", 32'(hsels), 32'h2);
        step(); haddr = 32'h60010004; htrans = 2'b10;
        #1 chk("rd_hsels", 32'(hsels), 32'h2);
        bus(1'b1, 1'b0, D1, "wr_data");
        step(); htrans = 2'b00;
        bus(1'b1, 1'b0, D1, "rd_data");
        step();
        bus(1'b1, 1'b0, 32'h0, "idle_after_rd");
        haddr = 32'h60000010;
        #1 chk("hsels_idle_htrans", 32'(hsels), 32'h1);
        haddr = 32'h70000000;
        #1 chk("hsels_unmapped", 32'(hsels), 32'h0);

        // single unmapped transfer
        htrans = 2'b10;
        step(); htrans = 2'b00;
        bus(1'b0, 1'b1, 32'h0, "unm_err1");
        step();
        bus(1'b1, 1'b1, 32'h0, "unm_err2");
        step();
        bus(1'b1, 1'b0, 32'h0, "unm_done");

        // back-to-back unmapped transfers
        htrans = 2'b10;
        step();
        bus(1'b0, 1'b1, 32'h0, "b2b_err1a");
        step();
        bus(1'b1, 1'b1, 32'h0, "b2b_err2a");
        step();
        bus(1'b0, 1'b1, 32'h0, "b2b_err1b");
        htrans = 2'b00;
        step();
        bus(1'b1, 1'b1, 32'h0, "b2b_err2b");
        step();
        bus(1'b1, 1'b0, 32'h0, "b2b_idle");

        // slave 0 hangs: expiry after 8 stall cycles
        hreadyouts = 2'b10; haddr = 32'h60000000; htrans = 2'b10;
        step(); htrans = 2'b00;
        bus(1'b0, 1'b0, D0, "to_stall1");
        repeat (7) step();
        bus(1'b0, 1'b0, D0, "to_stall8");
        chk("to_flag_pre", 32'(timeout_flag), 32'd0);
        step();
        bus(1'b0, 1'b1, 32'h0, "to_err1");
        chk("to_flag", 32'(timeout_flag), 32'd1);
        chk("to_id", 32'(timeout_id), 32'd0);
        step();
        bus(1'b1, 1'b1, 32'h0, "to_err2");
        haddr = 32'h60010004; htrans = 2'b10;
        step(); htrans = 2'b00;
        bus(1'b1, 1'b0, D1, "to_next_ok");
        chk("to_flag_sticky", 32'(timeout_flag), 32'd1);
        timeout_clr = 1'b1;
        step(); timeout_clr = 1'b0;
        #1 chk("clr_flag", 32'(timeout_flag), 32'd0);

        // slave 0 releases on stall cycle 8: completes OKAY
        haddr = 32'h60000000; htrans = 2'b10;
        step(); htrans = 2'b00;
        repeat (7) step();
        hreadyouts = 2'b11;
        bus(1'b1, 1'b0, D0, "late_ok");
        step();
        bus(1'b1, 1'b0, 32'h0, "late_idle");
        chk("late_flag", 32'(timeout_flag), 32'd0);

        // slave 1 hangs, clear pulsed in the expiry cycle
        hreadyouts = 2'b01; haddr = 32'h60010000; htrans = 2'b10;
        step(); htrans = 2'b00;
        repeat (7) step();
        timeout_clr = 1'b1;
        step(); timeout_clr = 1'b0;
        bus(1'b0, 1'b1, 32'h0, "clr_race_err1");
        chk("clr_race_flag", 32'(timeout_flag), 32'd1);
        chk("clr_race_id", 32'(timeout_id), 32'd1);
        step(); hreadyouts = 2'b11;
        step();
        bus(1'b1, 1'b0, 32'h0, "clr_race_done");

        // reset in the middle of a slave 0 stall
        hreadyouts = 2'b10; haddr = 32'h60000000; htrans = 2'b10;
        step(); htrans = 2'b00;
        step(); step();
        bus(1'b0, 1'b0, D0, "rst_stall");
        hreset = 1'b1;
        bus(1'b1, 1'b0, 32'h0, "rst_async");
        chk("rst_flag", 32'(timeout_flag), 32'd0);
        chk("rst_id", 32'(timeout_id), 32'd0);
        step(); hreset = 1'b0; hreadyouts = 2'b11;
        haddr = 32'h60010008; htrans = 2'b10;
        #1 chk("post_rst_hsels", 32'(hsels), 32'h2);
        step(); htrans = 2'b00; hresps = 2'b10;
        bus(1'b1, 1'b1, D1, "slave_err_pass");
        chk("slave_err_flag", 32'(timeout_flag), 32'd0);
        step(); hresps = 2'b00;
        bus(1'b1, 1'b0, 32'h0, "final_idle");

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
